// File: rtl/ibex_rf_write_ctrl.sv
// Write-port controller for the flop-based register file. It merges EX results and load
// returns into one registered write stream. Optional forwarding: IBEX_RF_WRITE_FWD_EN.
module ibex_rf_write_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 we_a_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
`ifdef IBEX_RF_WRITE_FWD_EN
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
`endif
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [4:0]           buf_addr_q [Depth];
  logic [DataWidth-1:0] buf_data_q [Depth];
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW:0]        count_q;
  logic [Depth-1:0]     buf_valid;
  logic                 buf_empty;
  logic                 lsu_accept;
  logic                 push;
  logic                 pop;
  logic                 sel_valid;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 ex_conflict;
  logic [4:0]           raddr [2];
  logic [1:0]           rd_hit;

  assign buf_empty   = (count_q == '0);
  assign lsu_ready_o = (count_q != (PtrW+1)'(Depth));
  assign lsu_accept  = lsu_valid_i && lsu_ready_o;
  assign raddr[0]    = raddr_a_i;
  assign raddr[1]    = raddr_b_i;

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    buf_valid = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      buf_valid[i] = ({1'b0, PtrW'(PtrW'(i) - rd_ptr_q)} < count_q);
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = ex_waddr_i;
    sel_data  = ex_wdata_i;
    pop       = 1'b0;
    push      = lsu_accept && (ex_valid_i || !buf_empty);
    if (ex_valid_i) begin
      sel_valid = 1'b1;
    end else if (!buf_empty) begin
      sel_valid = 1'b1;
      sel_addr  = buf_addr_q[rd_ptr_q];
      sel_data  = buf_data_q[rd_ptr_q];
      pop       = 1'b1;
    end else if (lsu_accept) begin
      sel_valid = 1'b1;
      sel_addr  = lsu_waddr_i;
      sel_data  = lsu_wdata_i;
    end
  end

  // An EX write overtaking a pending load to the same register means upstream scoreboarding failed.
  always_comb begin
    ex_conflict = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (buf_valid[i] && (buf_addr_q[i] == ex_waddr_i)) ex_conflict = 1'b1;
    end
    ex_conflict = ex_conflict && ex_valid_i && (ex_waddr_i != 5'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= lsu_waddr_i;
      buf_data_q[wr_ptr_q] <= lsu_wdata_i;
    end
  end

  // x0 writes are consumed by selection but never raise the enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      err_o     <= 1'b0;
    end else begin
      we_a_o <= sel_valid && (sel_addr != 5'd0);
      if (sel_valid) begin
        waddr_a_o <= sel_addr;
        wdata_a_o <= sel_data;
      end
      err_o <= ex_conflict;
    end
  end

  always_comb begin
    rd_hit = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_hit[p] = we_a_o && (waddr_a_o == raddr[p]);
      for (int unsigned i = 0; i < Depth; i++) begin
        if (buf_valid[i] && (buf_addr_q[i] == raddr[p])) rd_hit[p] = 1'b1;
      end
      rd_hit[p] = rd_hit[p] && (raddr[p] != 5'd0);
    end
  end

`ifdef IBEX_RF_WRITE_FWD_EN
  logic [DataWidth-1:0] rd_data [2];
  logic [PtrW-1:0]      age_idx;

  // Walk oldest to newest so the newest buffered match wins; the output register beats all.
  always_comb begin
    age_idx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      for (int unsigned k = 0; k < Depth; k++) begin
        age_idx = rd_ptr_q + PtrW'(k);
        if (({1'b0, PtrW'(k)} < count_q) && (buf_addr_q[age_idx] == raddr[p])) begin
          rd_data[p] = buf_data_q[age_idx];
        end
      end
      if (we_a_o && (waddr_a_o == raddr[p])) rd_data[p] = wdata_a_o;
    end
  end

  assign fwd_a_o      = rd_hit[0];
  assign fwd_b_o      = rd_hit[1];
  assign fwd_data_a_o = rd_data[0];
  assign fwd_data_b_o = rd_data[1];
  assign hazard_a_o   = 1'b0;
  assign hazard_b_o   = 1'b0;
`else
  assign hazard_a_o   = rd_hit[0];
  assign hazard_b_o   = rd_hit[1];
`endif

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Self-checking bench for ibex_rf_write_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_ibex_rf_write_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0;
  logic [4:0]    ex_waddr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [4:0]    lsu_waddr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          we;
  logic [4:0]    waddr;
  logic [DW-1:0] wdata;
  logic [4:0]    raddr_a = '0;
  logic [4:0]    raddr_b = '0;
  logic          hazard_a;
  logic          hazard_b;
  logic          err;
`ifdef IBEX_RF_WRITE_FWD_EN
  logic          fwd_a;
  logic          fwd_b;
  logic [DW-1:0] fwd_data_a;
  logic [DW-1:0] fwd_data_b;
`endif

  always #5 clk = ~clk;

  ibex_rf_write_ctrl #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_waddr_i  (lsu_waddr),
    .lsu_wdata_i  (lsu_wdata),
    .we_a_o       (we),
    .waddr_a_o    (waddr),
    .wdata_a_o    (wdata),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
`ifdef IBEX_RF_WRITE_FWD_EN
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .fwd_data_a_o (fwd_data_a),
    .fwd_data_b_o (fwd_data_b),
`endif
    .hazard_a_o   (hazard_a),
    .hazard_b_o   (hazard_b),
    .err_o        (err)
  );

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } entry_t;

  // Reference model: pending loads in arrival order plus the registered write it expects.
  entry_t        mq[$];
  logic          exp_we    = 1'b0;
  logic [4:0]    exp_waddr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_err   = 1'b0;
  int            checks    = 0;
  int            failures  = 0;
  bit            cmp_en    = 1'b0;

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_err   = 1'b0;
  endtask

  task automatic modelStep();
    bit     was_empty;
    bit     acc;
    bit     hit;
    entry_t e;
    was_empty = (mq.size() == 0);
    acc       = lsu_valid && (mq.size() != DEPTH);
    hit       = 1'b0;
    foreach (mq[i]) if (mq[i].addr == ex_waddr) hit = 1'b1;
    exp_err = ex_valid && (ex_waddr != 0) && hit;
    if (ex_valid) begin
      exp_we = (ex_waddr != 0); exp_waddr = ex_waddr; exp_wdata = ex_wdata;
    end else if (!was_empty) begin
      e = mq.pop_front();
      exp_we = (e.addr != 0); exp_waddr = e.addr; exp_wdata = e.data;
    end else if (acc) begin
      exp_we = (lsu_waddr != 0); exp_waddr = lsu_waddr; exp_wdata = lsu_wdata;
    end else begin
      exp_we = 1'b0;
    end
    if (acc && (ex_valid || !was_empty)) begin
      e.addr = lsu_waddr;
      e.data = lsu_wdata;
      mq.push_back(e);
    end
  endtask

  function automatic bit expHit(input logic [4:0] ra);
    if (ra == 0) return 1'b0;
    if (exp_we && (exp_waddr == ra)) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] expFwdData(input logic [4:0] ra);
    if (exp_we && (exp_waddr == ra)) return exp_wdata;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == ra) return mq[i].data;
    return '0;
  endfunction

  task automatic checkOutput();
    checkVal("we", we, exp_we);
    checkVal("err", err, exp_err);
    checkVal("lsu_ready", lsu_ready, mq.size() != DEPTH);
    if (exp_we) begin
      checkVal("waddr", waddr, exp_waddr);
      checkVal("wdata", wdata, exp_wdata);
    end
`ifdef IBEX_RF_WRITE_FWD_EN
    checkVal("fwd_a", fwd_a, expHit(raddr_a));
    checkVal("fwd_b", fwd_b, expHit(raddr_b));
    if (expHit(raddr_a)) checkVal("fwd_data_a", fwd_data_a, expFwdData(raddr_a));
    if (expHit(raddr_b)) checkVal("fwd_data_b", fwd_data_b, expFwdData(raddr_b));
    checkVal("hazard_a", hazard_a, 0);
    checkVal("hazard_b", hazard_b, 0);
`else
    checkVal("hazard_a", hazard_a, expHit(raddr_a));
    checkVal("hazard_b", hazard_b, expHit(raddr_b));
`endif
  endtask

  always @(negedge clk) if (cmp_en) checkOutput();

  // Each call closes the current cycle (model follows the DUT edge) and drives the next one.
  task automatic applyStimulus(input bit ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                               input bit lv, input logic [4:0] la, input logic [DW-1:0] ld,
                               input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    if (rst_n) modelStep();
    else modelReset();
    #1;
    ex_valid = ev;  ex_waddr = ea;  ex_wdata = ed;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    raddr_a = ra;   raddr_b = rb;
  endtask

  task automatic idle(input logic [4:0] ra);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ra, 5'd0);
  endtask

  task automatic checkHazardA(input string name, input bit exp);
`ifdef IBEX_RF_WRITE_FWD_EN
    checkVal(name, fwd_a, exp);
`else
    checkVal(name, hazard_a, exp);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    checkVal("reset_we", we, 0);
    checkVal("reset_ready", lsu_ready, 1);
    checkVal("reset_err", err, 0);
    checkVal("reset_waddr", waddr, 0);
    checkVal("reset_wdata", wdata, 0);
    checkVal("reset_hazard_a", hazard_a, 0);

    // Single EX write with a same-cycle reader.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    idle(5'd5);
    @(negedge clk);
    checkVal("ex_we", we, 1);
    checkVal("ex_waddr", waddr, 5);
    checkVal("ex_wdata", wdata, 32'hDEADBEEF);
    checkHazardA("ex_hazard_a", 1'b1);
`ifdef IBEX_RF_WRITE_FWD_EN
    checkVal("ex_fwd_data_a", fwd_data_a, 32'hDEADBEEF);
`endif
    idle(5'd0);
    idle(5'd0);

    // Loads colliding with three consecutive EX writes.
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'h2, 1'b1, 5'd8, 32'h22, 5'd0, 5'd0);
    @(negedge clk);
    checkVal("col_c1_waddr", waddr, 3);
    checkVal("col_c1_wdata", wdata, 1);
    applyStimulus(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    @(negedge clk);
    checkVal("col_c2_ready", lsu_ready, 0);
    checkVal("col_c2_wdata", wdata, 2);
    idle(5'd0);
    @(negedge clk);
    checkVal("col_c3_wdata", wdata, 3);
    idle(5'd0);
    @(negedge clk);
    checkVal("col_c4_waddr", waddr, 7);
    checkVal("col_c4_wdata", wdata, 32'h11);
    idle(5'd0);
    @(negedge clk);
    checkVal("col_c5_waddr", waddr, 8);
    checkVal("col_c5_wdata", wdata, 32'h22);
    idle(5'd0);

    // Simultaneous push and pop with one buffered entry.
    applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 5'd11, 5'd0);
    @(negedge clk);
    checkVal("pp_c1_waddr", waddr, 10);
    checkHazardA("pp_c1_hazard_a", 1'b1);
    idle(5'd9);
    @(negedge clk);
    checkVal("pp_c2_waddr", waddr, 11);
    checkVal("pp_c2_ready", lsu_ready, 1);
    checkHazardA("pp_c2_hazard_a", 1'b1);
    idle(5'd0);
    @(negedge clk);
    checkVal("pp_c3_waddr", waddr, 9);
    checkVal("pp_c3_wdata", wdata, 32'h99);
    idle(5'd0);
    @(negedge clk);
    checkVal("pp_c4_we", we, 0);

    // x0 writes are swallowed.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    idle(5'd0);
    @(negedge clk);
    checkVal("x0_we", we, 0);
    checkVal("x0_hazard_a", hazard_a, 0);

    // EX overtaking a buffered load to the same register.
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd4, 32'h40, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    idle(5'd0);
    @(negedge clk);
    checkVal("err_pulse", err, 1);
    checkVal("err_c2_wdata", wdata, 32'h40);
    idle(5'd0);
    @(negedge clk);
    checkVal("err_clear", err, 0);
    checkVal("err_c3_wdata", wdata, 32'h44);
    idle(5'd0);

    // Reset with a full buffer: the buffered loads must vanish.
    applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd16, 32'h10, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    @(negedge clk);
    checkVal("rst_full_ready", lsu_ready, 0);
    applyStimulus(1'b1, 5'd17, 32'h17, 1'b0, 5'd0, '0, 5'd13, 5'd15);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkVal("rst_mid_we", we, 0);
    checkVal("rst_mid_ready", lsu_ready, 1);
    idle(5'd0);
    idle(5'd13);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkVal("rst_after_we", we, 0);
      checkVal("rst_after_ready", lsu_ready, 1);
      checkHazardA("rst_after_hazard_a", 1'b0);
      idle(5'd13);
    end

    // Random traffic on a small address range to provoke collisions.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle(5'd0);
        rst_n = 1'b0;
        modelReset();
        idle(5'd0);
        rst_n = 1'b1;
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    repeat (4) idle(5'd0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
